// File: rtl/user_proj_counter_mc.sv
// user_proj_counter_mc: CHANNELS independent BITS-wide up/down counters behind a Wishbone slave.
// Channel 0's count drives the IO pads; the enabled done flags drive user_irq[0].
module user_proj_counter_mc #(
    parameter int unsigned BITS     = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned IO_PADS  = 38,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_dat_i,
    input  logic [31:0]        wbs_adr_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic [IO_PADS-1:0] io_out,
    output logic [IO_PADS-1:0] io_oeb,
    output logic [2:0]         user_irq
);
    localparam int unsigned IoW = (IO_PADS < BITS) ? IO_PADS : BITS;

    localparam int unsigned CtrlEn      = 0;
    localparam int unsigned CtrlDir     = 1;
    localparam int unsigned CtrlOneshot = 2;
    localparam int unsigned CtrlIrqEn   = 3;

    logic [BITS-1:0]     cnt_q  [CHANNELS];
    logic [BITS-1:0]     cnt_d  [CHANNELS];
    logic [BITS-1:0]     lim_q  [CHANNELS];
    logic [BITS-1:0]     lim_d  [CHANNELS];
    logic [3:0]          ctrl_q [CHANNELS];
    logic [3:0]          ctrl_d [CHANNELS];
    logic [CHANNELS-1:0] done_q, done_d;
    logic [CHANNELS-1:0] done_set, done_clr;
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic                irq_q, irq_d;

    logic                sel_hit, acc, wr_acc;
    logic [7:0]          chan;
    logic [1:0]          reg_sel;
    logic [31:0]         wmask32;
    logic [BITS-1:0]     wmask, wdat;
    logic [31:0]         rdata;
    logic                unused_adr;

    assign sel_hit    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:12] == BASE_ADR[31:12]);
    // A strobe still high during the ack cycle is the same access, not a new one.
    assign acc        = sel_hit & ~ack_q;
    assign wr_acc     = acc & wbs_we_i;
    assign chan       = wbs_adr_i[11:4];
    assign reg_sel    = wbs_adr_i[3:2];
    assign unused_adr = ^wbs_adr_i[1:0];

    assign wmask32 = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign wmask   = wmask32[BITS-1:0];
    assign wdat    = wbs_dat_i[BITS-1:0];

    // Per-channel counter step, with bus writes layered on top so the bus always wins.
    always_comb begin
        for (int n = 0; n < int'(CHANNELS); n++) begin
            cnt_d[n]    = cnt_q[n];
            lim_d[n]    = lim_q[n];
            ctrl_d[n]   = ctrl_q[n];
            done_set[n] = 1'b0;
            done_clr[n] = 1'b0;
            if (ctrl_q[n][CtrlEn]) begin
                if (!ctrl_q[n][CtrlDir]) begin
                    if (cnt_q[n] == lim_q[n]) begin
                        done_set[n] = 1'b1;
                        if (ctrl_q[n][CtrlOneshot]) begin
                            ctrl_d[n][CtrlEn] = 1'b0;
                        end else begin
                            cnt_d[n] = '0;
                        end
                    end else begin
                        cnt_d[n] = cnt_q[n] + BITS'(1);
                    end
                end else begin
                    if (cnt_q[n] == '0) begin
                        done_set[n] = 1'b1;
                        if (ctrl_q[n][CtrlOneshot]) begin
                            ctrl_d[n][CtrlEn] = 1'b0;
                        end else begin
                            cnt_d[n] = lim_q[n];
                        end
                    end else begin
                        cnt_d[n] = cnt_q[n] - BITS'(1);
                    end
                end
            end
            if (wr_acc && (chan == 8'(n))) begin
                case (reg_sel)
                    2'd0: ctrl_d[n] = (ctrl_q[n] & ~wmask[3:0]) | (wdat[3:0] & wmask[3:0]);
                    2'd1: lim_d[n]  = (lim_q[n] & ~wmask) | (wdat & wmask);
                    2'd2: cnt_d[n]  = (cnt_q[n] & ~wmask) | (wdat & wmask);
                    default: done_clr[n] = wmask[0] & wdat[0];
                endcase
            end
            // A terminal event in the same cycle as a clear keeps DONE set.
            done_d[n] = done_set[n] | (done_q[n] & ~done_clr[n]);
        end
    end

    // Register read mux; out-of-range channels read as zero.
    always_comb begin
        rdata = '0;
        for (int n = 0; n < int'(CHANNELS); n++) begin
            if (chan == 8'(n)) begin
                case (reg_sel)
                    2'd0:    rdata = 32'(ctrl_q[n]);
                    2'd1:    rdata = 32'(lim_q[n]);
                    2'd2:    rdata = 32'(cnt_q[n]);
                    default: rdata = 32'(done_q[n]);
                endcase
            end
        end
    end

    // Bus response and interrupt next-state.
    always_comb begin
        ack_d = acc;
        dat_d = (acc && !wbs_we_i) ? rdata : '0;
        irq_d = 1'b0;
        for (int n = 0; n < int'(CHANNELS); n++) begin
            irq_d = irq_d | (done_q[n] & ctrl_q[n][CtrlIrqEn]);
        end
    end

    // All state, synchronously reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int n = 0; n < int'(CHANNELS); n++) begin
                cnt_q[n]  <= '0;
                lim_q[n]  <= '0;
                ctrl_q[n] <= '0;
            end
            done_q <= '0;
            ack_q  <= 1'b0;
            dat_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            for (int n = 0; n < int'(CHANNELS); n++) begin
                cnt_q[n]  <= cnt_d[n];
                lim_q[n]  <= lim_d[n];
                ctrl_q[n] <= ctrl_d[n];
            end
            done_q <= done_d;
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            irq_q  <= irq_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign io_out    = IO_PADS'(cnt_q[0][IoW-1:0]);
    assign io_oeb    = '0;
    assign user_irq  = {2'b00, irq_q};

endmodule

// File: tb/tb_user_proj_counter_mc.sv
// Bench for user_proj_counter_mc: directed scenarios plus randomized bus traffic, all checked
// against a cycle-stepped reference model of the register/counter rules.
module tb_user_proj_counter_mc;
    localparam int unsigned NCH  = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat_i = '0, adr = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [37:0] io_out, io_oeb;
    logic [2:0]  user_irq;

    int nvec = 0;
    int nerr = 0;

    // Reference model state
    logic [31:0] m_cnt  [NCH];
    logic [31:0] m_lim  [NCH];
    logic [3:0]  m_ctrl [NCH];
    logic        m_done [NCH];
    logic        m_irq;

    always #5 clk = ~clk;

    user_proj_counter_mc #(
        .BITS(32), .CHANNELS(4), .IO_PADS(38), .BASE_ADR(BASE)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o), .io_out(io_out), .io_oeb(io_oeb), .user_irq(user_irq)
    );

    function automatic logic [31:0] reg_adr(input int unsigned ch, input int unsigned rg);
        reg_adr = BASE | 32'(ch << 4) | 32'(rg << 2);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        merge = old;
        for (int b = 0; b < 4; b++) if (s[b]) merge[8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < NCH; n++) begin
            m_cnt[n] = '0; m_lim[n] = '0; m_ctrl[n] = '0; m_done[n] = 1'b0;
        end
        m_irq = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned ch;
        ch = 32'(a[11:4]);
        model_read = '0;
        if (ch < NCH) begin
            case (a[3:2])
                2'd0:    model_read = {28'd0, m_ctrl[ch]};
                2'd1:    model_read = m_lim[ch];
                2'd2:    model_read = m_cnt[ch];
                default: model_read = {31'd0, m_done[ch]};
            endcase
        end
    endfunction

    // One clock of the model: counters advance from old state, then an accepted write overrides.
    function automatic void model_step(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] s);
        logic [31:0] nc [NCH];
        logic [31:0] nl [NCH];
        logic [3:0]  nctrl [NCH];
        logic        hit [NCH];
        logic        clr [NCH];
        logic [31:0] tmp, term;
        logic        down, irq_n;
        int unsigned ch;
        irq_n = 1'b0;
        for (int n = 0; n < NCH; n++) begin
            irq_n    = irq_n | (m_done[n] & m_ctrl[n][3]);
            nc[n]    = m_cnt[n];
            nl[n]    = m_lim[n];
            nctrl[n] = m_ctrl[n];
            hit[n]   = 1'b0;
            clr[n]   = 1'b0;
            if (m_ctrl[n][0]) begin
                down = m_ctrl[n][1];
                term = down ? 32'd0 : m_lim[n];
                if (m_cnt[n] == term) begin
                    hit[n] = 1'b1;
                    if (m_ctrl[n][2]) nctrl[n][0] = 1'b0;
                    else nc[n] = down ? m_lim[n] : 32'd0;
                end else begin
                    nc[n] = down ? m_cnt[n] - 32'd1 : m_cnt[n] + 32'd1;
                end
            end
        end
        ch = 32'(a[11:4]);
        if (wr && ch < NCH) begin
            case (a[3:2])
                2'd0: begin
                    tmp = merge({28'd0, m_ctrl[ch]}, d, s);
                    nctrl[ch] = tmp[3:0];
                end
                2'd1:    nl[ch] = merge(m_lim[ch], d, s);
                2'd2:    nc[ch] = merge(m_cnt[ch], d, s);
                default: clr[ch] = s[0] & d[0];
            endcase
        end
        for (int n = 0; n < NCH; n++) begin
            m_cnt[n]  = nc[n];
            m_lim[n]  = nl[n];
            m_ctrl[n] = nctrl[n];
            m_done[n] = hit[n] | (m_done[n] & ~clr[n]);
        end
        m_irq = irq_n;
    endfunction

    // Advance one clock: model first (using the inputs the DUT will sample), then the edge.
    task automatic tick(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        if (rst) model_reset();
        else model_step(wr, a, d, s);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 4'h0);
    endtask

    // One Wishbone access: strobe for one edge, then one edge with strobe low (ack falls).
    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic ack1, output logic [31:0] rd,
                             output logic [31:0] exp);
        logic hit;
        hit = (a[31:12] == 20'h30000);
        exp = model_read(a);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        tick(w & hit, a, d, s);
        ack1 = wbs_ack_o;
        rd   = wbs_dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        tick(1'b0, a, d, s);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic        ack;
        logic [31:0] rd, exp;
        wb_access(1'b1, a, d, 4'hF, ack, rd, exp);
    endtask

    task automatic test_reset();
        logic        ack;
        logic [31:0] rd, exp;
        rst = 1'b1; stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE;
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, BASE, '0, 4'h0);
            nvec++;
            if (wbs_ack_o !== 1'b0) begin
                nerr++; $display("FAIL reset_ack: got %b want 0", wbs_ack_o);
            end
        end
        rst = 1'b0; stb = 1'b0; cyc = 1'b0;
        nvec++;
        if (io_out !== 38'd0 || user_irq !== 3'd0 || wbs_dat_o !== 32'd0 || io_oeb !== 38'd0) begin
            nerr++;
            $display("FAIL reset_outputs: io_out=%h irq=%b dat=%h oeb=%h want all 0",
                     io_out, user_irq, wbs_dat_o, io_oeb);
        end
        for (int n = 0; n < NCH; n++) begin
            for (int r = 0; r < 4; r++) begin
                wb_access(1'b0, reg_adr(n, r), '0, 4'hF, ack, rd, exp);
                nvec++;
                if (ack !== 1'b1 || rd !== 32'd0) begin
                    nerr++;
                    $display("FAIL reset_reg ch%0d r%0d: ack=%b data=%h want ack=1 data=0",
                             n, r, ack, rd);
                end
            end
        end
    endtask

    task automatic test_up_wrap();
        logic        ack;
        logic [31:0] rd, exp, prev;
        wb_write(reg_adr(0, 1), 32'd3);
        wb_write(reg_adr(0, 0), 32'h1);
        prev = io_out[31:0];
        for (int k = 0; k < 10; k++) begin
            idle(1);
            nvec++;
            if (io_out !== {6'd0, m_cnt[0]}) begin
                nerr++; $display("FAIL up_wrap_model k%0d: io_out=%h want %h", k, io_out, m_cnt[0]);
            end
            nvec++;
            if (io_out[31:0] !== ((prev + 32'd1) % 32'd4)) begin
                nerr++;
                $display("FAIL up_wrap_seq k%0d: io_out=%h want %h", k, io_out,
                         (prev + 32'd1) % 32'd4);
            end
            prev = io_out[31:0];
        end
        wb_access(1'b0, reg_adr(0, 3), '0, 4'hF, ack, rd, exp);
        nvec++;
        if (rd !== 32'd1) begin
            nerr++; $display("FAIL up_wrap_done: got %h want 1", rd);
        end
        wb_write(reg_adr(0, 0), 32'h0);
        wb_write(reg_adr(0, 3), 32'h1);
        wb_access(1'b0, reg_adr(0, 3), '0, 4'hF, ack, rd, exp);
        nvec++;
        if (rd !== 32'd0) begin
            nerr++; $display("FAIL up_wrap_w1c: got %h want 0", rd);
        end
    endtask

    task automatic test_down_oneshot();
        logic        ack;
        logic [31:0] rd, exp;
        wb_write(reg_adr(1, 1), 32'd5);
        wb_write(reg_adr(1, 2), 32'd2);
        wb_write(reg_adr(1, 0), 32'hF);
        for (int k = 0; k < 6; k++) begin
            idle(1);
            nvec++;
            if (user_irq !== {2'b00, m_irq}) begin
                nerr++; $display("FAIL down_irq_lag k%0d: irq=%b want %b", k, user_irq, m_irq);
            end
        end
        wb_access(1'b0, reg_adr(1, 2), '0, 4'hF, ack, rd, exp);
        nvec++;
        if (rd !== 32'd0) begin
            nerr++; $display("FAIL down_count_hold: got %h want 0", rd);
        end
        wb_access(1'b0, reg_adr(1, 0), '0, 4'hF, ack, rd, exp);
        nvec++;
        if (rd !== 32'hE) begin
            nerr++; $display("FAIL down_ctrl_en_clear: got %h want e", rd);
        end
        nvec++;
        if (user_irq !== 3'b001) begin
            nerr++; $display("FAIL down_irq_set: got %b want 001", user_irq);
        end
        wb_write(reg_adr(1, 3), 32'h1);
        nvec++;
        if (user_irq !== 3'b000) begin
            nerr++; $display("FAIL down_irq_clear: got %b want 000", user_irq);
        end
    endtask

    task automatic test_byte_write();
        logic        ack;
        logic [31:0] rd, exp;
        wb_access(1'b1, reg_adr(2, 1), 32'hFFFF_ABFF, 4'b0010, ack, rd, exp);
        wb_access(1'b0, reg_adr(2, 1), '0, 4'hF, ack, rd, exp);
        nvec++;
        if (rd !== 32'h0000_AB00 || rd !== exp) begin
            nerr++; $display("FAIL byte_write: got %h want 0000ab00", rd);
        end
    endtask

    task automatic test_conflicts();
        logic        ack;
        logic [31:0] rd, exp;
        int          guard;
        // COUNT write beats the increment
        wb_write(reg_adr(3, 1), 32'hFFFF_FFFF);
        wb_write(reg_adr(3, 0), 32'h1);
        idle(3);
        wb_write(reg_adr(3, 2), 32'h10);
        wb_access(1'b0, reg_adr(3, 2), '0, 4'hF, ack, rd, exp);
        nvec++;
        if ((rd !== 32'h10 && rd !== 32'h11) || rd !== exp) begin
            nerr++; $display("FAIL count_write_wins: got %h want %h", rd, exp);
        end
        // W1C landing on a terminal cycle
        wb_write(reg_adr(3, 0), 32'h0);
        wb_write(reg_adr(3, 2), 32'h0);
        wb_write(reg_adr(3, 1), 32'd5);
        wb_write(reg_adr(3, 0), 32'h1);
        guard = 0;
        while (m_cnt[3] != m_lim[3] && guard < 20) begin
            idle(1); guard++;
        end
        nvec++;
        if (guard >= 20) begin
            nerr++; $display("FAIL terminal_wait: model count %h never reached limit", m_cnt[3]);
        end
        wb_write(reg_adr(3, 3), 32'h1);
        wb_access(1'b0, reg_adr(3, 3), '0, 4'hF, ack, rd, exp);
        nvec++;
        if (rd !== 32'd1) begin
            nerr++; $display("FAIL w1c_vs_set: got %h want 1", rd);
        end
        // LIMIT = 0 up: DONE every cycle, COUNT pinned at 0
        wb_write(reg_adr(3, 0), 32'h0);
        wb_write(reg_adr(3, 2), 32'h0);
        wb_write(reg_adr(3, 1), 32'h0);
        wb_write(reg_adr(3, 0), 32'h1);
        wb_write(reg_adr(3, 3), 32'h1);
        wb_access(1'b0, reg_adr(3, 3), '0, 4'hF, ack, rd, exp);
        nvec++;
        if (rd !== 32'd1) begin
            nerr++; $display("FAIL limit0_done: got %h want 1", rd);
        end
        wb_access(1'b0, reg_adr(3, 2), '0, 4'hF, ack, rd, exp);
        nvec++;
        if (rd !== 32'd0) begin
            nerr++; $display("FAIL limit0_count: got %h want 0", rd);
        end
        wb_write(reg_adr(3, 0), 32'h0);
        // CTRL write beats one-shot EN clear
        wb_write(reg_adr(1, 0), 32'h0);
        wb_write(reg_adr(1, 2), 32'h0);
        wb_write(reg_adr(1, 1), 32'd3);
        wb_write(reg_adr(1, 0), 32'h5);
        guard = 0;
        while (m_cnt[1] != m_lim[1] && guard < 20) begin
            idle(1); guard++;
        end
        wb_write(reg_adr(1, 0), 32'h1);
        wb_access(1'b0, reg_adr(1, 0), '0, 4'hF, ack, rd, exp);
        nvec++;
        if (rd !== 32'h1) begin
            nerr++; $display("FAIL ctrl_write_wins: got %h want 1", rd);
        end
        wb_write(reg_adr(1, 0), 32'h0);
    endtask

    task automatic test_decode();
        logic        ack;
        logic [31:0] rd, exp;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3001_0000; dat_i = 32'h1; sel = 4'hF;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, adr, dat_i, sel);
            nvec++;
            if (wbs_ack_o !== 1'b0) begin
                nerr++; $display("FAIL decode_miss k%0d: ack=%b want 0", k, wbs_ack_o);
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        idle(1);
        wb_access(1'b1, BASE | 32'h50, 32'hFFFF_FFFF, 4'hF, ack, rd, exp);
        nvec++;
        if (ack !== 1'b1) begin
            nerr++; $display("FAIL ch5_write_ack: ack=%b want 1", ack);
        end
        wb_access(1'b0, BASE | 32'h50, '0, 4'hF, ack, rd, exp);
        nvec++;
        if (ack !== 1'b1 || rd !== 32'd0) begin
            nerr++; $display("FAIL ch5_read: ack=%b data=%h want ack=1 data=0", ack, rd);
        end
        // Held strobe: ack 0,1,0,1,...
        exp = model_read(reg_adr(2, 1));
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = reg_adr(2, 1);
        nvec++;
        if (wbs_ack_o !== 1'b0) begin
            nerr++; $display("FAIL held_stb_pre: ack=%b want 0", wbs_ack_o);
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, adr, '0, 4'h0);
            nvec++;
            if (wbs_ack_o !== ((k % 2) == 0)) begin
                nerr++;
                $display("FAIL held_stb k%0d: ack=%b want %b", k, wbs_ack_o, (k % 2) == 0);
            end
            if ((k % 2) == 0) begin
                nvec++;
                if (wbs_dat_o !== exp) begin
                    nerr++; $display("FAIL held_stb_data k%0d: got %h want %h", k, wbs_dat_o, exp);
                end
            end
        end
        stb = 1'b0; cyc = 1'b0;
        idle(1);
    endtask

    task automatic test_reset_mid();
        logic        ack;
        logic [31:0] rd, exp;
        wb_write(reg_adr(0, 1), 32'd7);
        wb_write(reg_adr(0, 0), 32'h1);
        idle(2);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = reg_adr(0, 2); dat_i = 32'h55; sel = 4'hF;
        rst = 1'b1;
        tick(1'b0, adr, dat_i, sel);
        rst = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        nvec++;
        if (wbs_ack_o !== 1'b0) begin
            nerr++; $display("FAIL reset_mid_ack: ack=%b want 0", wbs_ack_o);
        end
        idle(1);
        nvec++;
        if (wbs_ack_o !== 1'b0 || io_out !== 38'd0) begin
            nerr++; $display("FAIL reset_mid_after: ack=%b io_out=%h want 0,0", wbs_ack_o, io_out);
        end
        wb_access(1'b0, reg_adr(0, 0), '0, 4'hF, ack, rd, exp);
        nvec++;
        if (rd !== 32'd0) begin
            nerr++; $display("FAIL reset_mid_ctrl: got %h want 0", rd);
        end
    endtask

    task automatic test_random();
        logic        ack, w;
        logic [31:0] rd, exp, d;
        int unsigned ch, rg;
        logic [3:0]  s;
        for (int i = 0; i < 250; i++) begin
            ch = $urandom_range(0, 5);
            rg = $urandom_range(0, 3);
            w  = 1'($urandom_range(0, 1));
            s  = 4'($urandom_range(0, 15));
            d  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
            if (rg == 0) d = 32'($urandom_range(0, 15));
            wb_access(w, reg_adr(ch, rg), d, s, ack, rd, exp);
            nvec++;
            if (ack !== 1'b1) begin
                nerr++; $display("FAIL rand_ack i%0d: ack=%b want 1", i, ack);
            end
            if (!w) begin
                nvec++;
                if (rd !== exp) begin
                    nerr++;
                    $display("FAIL rand_read i%0d ch%0d r%0d: got %h want %h", i, ch, rg, rd, exp);
                end
            end
            idle($urandom_range(0, 3));
            nvec++;
            if (io_out !== {6'd0, m_cnt[0]} || user_irq !== {2'b00, m_irq}) begin
                nerr++;
                $display("FAIL rand_io i%0d: io_out=%h irq=%b want %h %b", i, io_out, user_irq,
                         m_cnt[0], m_irq);
            end
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_up_wrap();
        test_down_oneshot();
        test_byte_write();
        test_conflicts();
        test_decode();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
